div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Shares one signed divider/modulo datapath (32-bit dividend, 16-bit divisor, 17-bit result, mode select, valid_input/valid_output handshake) between two requesters.
- Accepts one request at a time under round-robin arbitration and issues it to the divider as a single-cycle valid_input pulse.
- Waits for valid_output, then returns the result to the granted requester.
- Short-circuits divide-by-zero and flags divider timeouts.

Parameters:
DIVIDEND_W, 32, dividend width
DIVISOR_W, 16, divisor width
RESULT_W, 17, divider result width
TIMEOUT_CYCLES, 64, max cycles spent in WAIT before giving up (>=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
rq0_valid  input  1  requester 0 has an operation
rq0_ready  output  1  requester 0 accepted this cycle
rq0_dividend  input  DIVIDEND_W  signed dividend
rq0_divisor  input  DIVISOR_W  signed divisor
rq0_mode  input  1  passed unchanged to divider mode
rq1_valid, rq1_ready, rq1_dividend, rq1_divisor, rq1_mode  as requester 0
rsp0_valid  output  1  one-cycle response pulse to requester 0
rsp1_valid  output  1  one-cycle response pulse to requester 1
rsp_result  output  RESULT_W  signed result, shared, valid with rspN_valid
rsp_status  output  2  00 ok, 01 divide-by-zero, 10 timeout
div_dividend  output  DIVIDEND_W  to divider
div_divisor  output  DIVISOR_W  to divider
div_mode  output  1  to divider
div_valid_input  output  1  one-cycle issue pulse
div_valid_output  input  1  divider result ready
div_final_output  input  RESULT_W  divider result
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state IDLE; every output 0; operand/result registers 0; timeout counter 0; priority pointer = requester 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, one or both rqN_valid high:
  - Grant goes to the pointer requester if it is valid, else to the other.
  - rqN_ready for the granted requester is asserted combinationally in that cycle; the transfer completes on valid&ready.
  - Operands, mode and grant id are latched. The pointer moves to the non-granted requester.
  - The non-granted requester sees ready=0 and must hold its request.
- IDLE, divisor latched as 0: go directly to RESP with status 01, result 0. The divider is never issued.
- IDLE, nonzero divisor: go to ISSUE.
- ISSUE:
  - div_valid_input=1 for exactly one cycle; div_* operands are driven from the latches and held stable through WAIT.
  - Next state WAIT; counter cleared.
- WAIT:
  - On div_valid_output=1: capture div_final_output, status 00, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without valid_output, go to RESP with status 10, result 0.
- RESP:
  - rspN_valid=1 for the granted requester for one cycle; rsp_result/rsp_status valid in that cycle only, then return to IDLE.
  - There is no response backpressure.
  - rq*_ready stays 0 in all non-IDLE states.
- Latency, nonzero divisor: accept at cycle T → issue T+1 → WAIT from T+2. Response appears one cycle after the valid_output cycle. The divider's own latency is L ≥ 1 cycles after issue.
- Divide-by-zero latency: accept at T, response at T+1.
- Throughput: at most one operation in flight. The next accept occurs no earlier than the cycle after RESP.
- div_valid_output outside WAIT is ignored.
- A timeout is a fatal diagnostic. A late divider result after a timeout is not tracked, and the system must reset.
- Signed values pass through unmodified. The block performs no arithmetic on operands. The zero check compares all DIVISOR_W bits to 0.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No response is emitted for the aborted request.
- div_mode is the latched rqN_mode. Its meaning is defined by the divider.

Test Plan:
- Bench divider model returns dividend/divisor for mode=0 and dividend%divisor for mode=1 after 3 cycles.
- Single request: rq0 80/3 mode=0 → rq0_ready at T, div_valid_input at T+1 with 80/3, rsp0_valid with result 26, status 00. Same with mode=1 → result 2.
- Simultaneous: rq0 and rq1 both valid after reset, rq0 = −80/3, rq1 = 100/7, mode=0 → rq0 served first (result −26), then rq1 (result 14). Repeat with both held valid → grants alternate 1,0,1.
- Divide-by-zero: rq1 50/0 → rq1_ready at T, rsp1_valid at T+1 with status 01, result 0; div_valid_input never pulses.
- Timeout: TIMEOUT_CYCLES=8, model never responds → rsp0_valid with status 10 exactly 8 cycles after entering WAIT; busy deasserts the following cycle.
- Reset during WAIT: pull reset low for 1 cycle → all outputs 0 immediately, no rsp pulse. A subsequent rq1 request completes normally with priority reset to rq0.

Source files
------------

// File: rtl/div_arbiter_if.sv
// Requester, response and divider-side signals of the shared divider arbiter.
// slave is the arbiter's view; master is the environment (requesters + divider).
interface div_arbiter_if #(
   parameter int unsigned DIVIDEND_W = 32,
   parameter int unsigned DIVISOR_W  = 16,
   parameter int unsigned RESULT_W   = 17
);
   logic                  rq0_valid;
   logic                  rq0_ready;
   logic [DIVIDEND_W-1:0] rq0_dividend;
   logic [DIVISOR_W-1:0]  rq0_divisor;
   logic                  rq0_mode;

   logic                  rq1_valid;
   logic                  rq1_ready;
   logic [DIVIDEND_W-1:0] rq1_dividend;
   logic [DIVISOR_W-1:0]  rq1_divisor;
   logic                  rq1_mode;

   logic                  rsp0_valid;
   logic                  rsp1_valid;
   logic [RESULT_W-1:0]   rsp_result;
   logic [1:0]            rsp_status;

   logic [DIVIDEND_W-1:0] div_dividend;
   logic [DIVISOR_W-1:0]  div_divisor;
   logic                  div_mode;
   logic                  div_valid_input;
   logic                  div_valid_output;
   logic [RESULT_W-1:0]   div_final_output;

   logic                  busy;

   modport slave (
      input  rq0_valid, rq0_dividend, rq0_divisor, rq0_mode,
      input  rq1_valid, rq1_dividend, rq1_divisor, rq1_mode,
      input  div_valid_output, div_final_output,
      output rq0_ready, rq1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_status,
      output div_dividend, div_divisor, div_mode, div_valid_input, busy
   );

   modport master (
      output rq0_valid, rq0_dividend, rq0_divisor, rq0_mode,
      output rq1_valid, rq1_dividend, rq1_divisor, rq1_mode,
      output div_valid_output, div_final_output,
      input  rq0_ready, rq1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_status,
      input  div_dividend, div_divisor, div_mode, div_valid_input, busy
   );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider between two requesters, one operation
// in flight; short-circuits divide-by-zero and reports divider timeouts.
module div_arbiter #(
   parameter int unsigned DIVIDEND_W     = 32,
   parameter int unsigned DIVISOR_W      = 16,
   parameter int unsigned RESULT_W       = 17,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic          clk,
   input  logic          reset,
   div_arbiter_if.slave  bus
);
   localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]      ST_OK    = 2'b00;
   localparam logic [1:0]      ST_DBZ   = 2'b01;
   localparam logic [1:0]      ST_TMO   = 2'b10;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   state_t                state_q, state_d;
   logic                  ptr_q, ptr_d;
   logic                  gnt_q, gnt_d;
   logic [DIVIDEND_W-1:0] dividend_q, dividend_d;
   logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
   logic                  mode_q, mode_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [RESULT_W-1:0]   result_q, result_d;
   logic [1:0]            status_q, status_d;
   logic                  rsp0_q, rsp0_d, rsp1_q, rsp1_d;
   logic                  issue_q, issue_d;
   logic                  busy_q, busy_d;

   logic                  pick_c;
   logic [DIVISOR_W-1:0]  pick_divisor_c;
   logic                  ready0_c, ready1_c;

   // Pointer requester wins if valid, otherwise the other one.
   assign pick_c         = ptr_q ? bus.rq1_valid : ~bus.rq0_valid;
   assign pick_divisor_c = pick_c ? bus.rq1_divisor : bus.rq0_divisor;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnt_d      = gnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      mode_d     = mode_q;
      cnt_d      = cnt_q;
      result_d   = '0;
      status_d   = ST_OK;
      rsp0_d     = 1'b0;
      rsp1_d     = 1'b0;
      issue_d    = 1'b0;
      ready0_c   = 1'b0;
      ready1_c   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.rq0_valid || bus.rq1_valid) begin
               ready0_c   = ~pick_c;
               ready1_c   = pick_c;
               gnt_d      = pick_c;
               ptr_d      = ~pick_c;
               dividend_d = pick_c ? bus.rq1_dividend : bus.rq0_dividend;
               divisor_d  = pick_divisor_c;
               mode_d     = pick_c ? bus.rq1_mode : bus.rq0_mode;
               if (pick_divisor_c == '0) begin
                  state_d  = RESP;
                  status_d = ST_DBZ;
                  rsp0_d   = ~pick_c;
                  rsp1_d   = pick_c;
               end else begin
                  state_d = ISSUE;
                  issue_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = '0;
         end
         WAIT: begin
            if (bus.div_valid_output) begin
               state_d  = RESP;
               result_d = bus.div_final_output;
               rsp0_d   = ~gnt_q;
               rsp1_d   = gnt_q;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = RESP;
               status_d = ST_TMO;
               rsp0_d   = ~gnt_q;
               rsp1_d   = gnt_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ptr_q      <= 1'b0;
         gnt_q      <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         mode_q     <= 1'b0;
         cnt_q      <= '0;
         result_q   <= '0;
         status_q   <= ST_OK;
         rsp0_q     <= 1'b0;
         rsp1_q     <= 1'b0;
         issue_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         mode_q     <= mode_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         status_q   <= status_d;
         rsp0_q     <= rsp0_d;
         rsp1_q     <= rsp1_d;
         issue_q    <= issue_d;
         busy_q     <= busy_d;
      end
   end

   // Ready is the only combinational output; held low while reset is asserted.
   assign bus.rq0_ready       = ready0_c & reset;
   assign bus.rq1_ready       = ready1_c & reset;
   assign bus.rsp0_valid      = rsp0_q;
   assign bus.rsp1_valid      = rsp1_q;
   assign bus.rsp_result      = result_q;
   assign bus.rsp_status      = status_q;
   assign bus.div_dividend    = dividend_q;
   assign bus.div_divisor     = divisor_q;
   assign bus.div_mode        = mode_q;
   assign bus.div_valid_input = issue_q;
   assign bus.busy            = busy_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: queued requester drivers, a 3-cycle divider model and
// a scoreboard checking responses, routing, latency and arbitration order.
module tb_div_arbiter;
   localparam int unsigned TMO     = 8;
   localparam int          LAT_OK  = 5;
   localparam int          LAT_DBZ = 1;
   localparam int          LAT_TMO = 2 + TMO;
   localparam logic [1:0]  S_OK    = 2'b00;
   localparam logic [1:0]  S_DBZ   = 2'b01;
   localparam logic [1:0]  S_TMO   = 2'b10;

   typedef struct {
      logic        id;
      logic [31:0] dvd;
      logic [15:0] dvs;
      logic        mode;
      logic [16:0] res;
      logic [1:0]  st;
   } op_t;

   typedef struct {
      op_t op;
      int  exp_cyc;
   } sb_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   div_arbiter_if bus ();

   div_arbiter #(
      .DIVIDEND_W(32), .DIVISOR_W(16), .RESULT_W(17), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   op_t  q0[$];
   op_t  q1[$];
   op_t  cur[2];
   bit   drv_valid[2];
   int   drv_taken[2];
   int   acc_cnt[2];
   sb_t  sb[$];
   int   acc_log[$];
   sb_t  mon_e;
   op_t  last_op;
   int   last_acc_cyc = -100;
   int   issue_cnt = 0;
   bit   rsp_prev = 1'b0;
   bit   div_en = 1'b1;
   bit   stray = 1'b0;
   op_t  tbl[8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic op_t mk(input logic id, input int dvd, input int dvs, input logic mode,
                              input int res, input logic [1:0] st);
      op_t o;
      o.id = id; o.dvd = 32'(dvd); o.dvs = 16'(dvs); o.mode = mode;
      o.res = 17'(res); o.st = st;
      return o;
   endfunction

   function automatic int lat(input logic [1:0] st);
      if (st == S_DBZ) return LAT_DBZ;
      if (st == S_TMO) return LAT_TMO;
      return LAT_OK;
   endfunction

   function automatic logic [127:0] outs();
      return 128'({bus.rq0_ready, bus.rq1_ready, bus.rsp0_valid, bus.rsp1_valid,
                   bus.rsp_result, bus.rsp_status, bus.div_dividend, bus.div_divisor,
                   bus.div_mode, bus.div_valid_input, bus.busy});
   endfunction

   function automatic logic [16:0] div_calc(input logic [31:0] a, input logic [15:0] b,
                                             input logic m);
      int q;
      if (m) q = $signed(a) % $signed(b);
      else   q = $signed(a) / $signed(b);
      return 17'(q);
   endfunction

   // Divider model: result valid 3 cycles after the issue pulse.
   logic [31:0] m_a;
   logic [15:0] m_b;
   logic        m_m;
   int          pend;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend                 <= 0;
         bus.div_valid_output <= 1'b0;
         bus.div_final_output <= '0;
      end else begin
         bus.div_valid_output <= 1'b0;
         if (bus.div_valid_input && div_en) begin
            pend <= 2;
            m_a  <= bus.div_dividend;
            m_b  <= bus.div_divisor;
            m_m  <= bus.div_mode;
         end else if (pend == 1) begin
            pend                 <= 0;
            bus.div_valid_output <= 1'b1;
            bus.div_final_output <= div_calc(m_a, m_b, m_m);
         end else if (pend > 1) begin
            pend <= pend - 1;
         end
         if (stray) begin
            bus.div_valid_output <= 1'b1;
            bus.div_final_output <= 17'h0abcd;
         end
      end
   end

   // Requester drivers: hold each op valid until the monitor sees it accepted.
   initial begin
      cur[0] = mk(0, 0, 0, 0, 0, S_OK);
      cur[1] = mk(1, 0, 0, 0, 0, S_OK);
      drv_valid[0] = 1'b0; drv_valid[1] = 1'b0;
      drv_taken[0] = 0;    drv_taken[1] = 0;
      bus.rq0_valid = 1'b0; bus.rq0_dividend = '0; bus.rq0_divisor = '0; bus.rq0_mode = 1'b0;
      bus.rq1_valid = 1'b0; bus.rq1_dividend = '0; bus.rq1_divisor = '0; bus.rq1_mode = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         for (int n = 0; n < 2; n++) begin
            if (drv_valid[n] && acc_cnt[n] != drv_taken[n]) begin
               drv_valid[n] = 1'b0;
               drv_taken[n] = acc_cnt[n];
            end
            if (!drv_valid[n]) begin
               if (n == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); drv_valid[0] = 1'b1; end
               if (n == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); drv_valid[1] = 1'b1; end
            end
         end
         bus.rq0_valid = drv_valid[0]; bus.rq0_dividend = cur[0].dvd;
         bus.rq0_divisor = cur[0].dvs; bus.rq0_mode = cur[0].mode;
         bus.rq1_valid = drv_valid[1]; bus.rq1_dividend = cur[1].dvd;
         bus.rq1_divisor = cur[1].dvs; bus.rq1_mode = cur[1].mode;
      end
   end

   // Monitor: scoreboard push on accept, pop and compare on response.
   always @(negedge clk) begin
      if (!reset) begin
         sb.delete();
         rsp_prev = 1'b0;
      end else begin
         if (bus.rq0_valid && bus.rq0_ready) begin
            mon_e.op = cur[0]; mon_e.exp_cyc = cyc + lat(cur[0].st);
            sb.push_back(mon_e); acc_log.push_back(0); acc_cnt[0]++;
            last_op = cur[0]; last_acc_cyc = cyc;
         end
         if (bus.rq1_valid && bus.rq1_ready) begin
            mon_e.op = cur[1]; mon_e.exp_cyc = cyc + lat(cur[1].st);
            sb.push_back(mon_e); acc_log.push_back(1); acc_cnt[1]++;
            last_op = cur[1]; last_acc_cyc = cyc;
         end
         if (bus.div_valid_input) begin
            issue_cnt++;
            chk("issue_cycle", 128'(cyc), 128'(last_acc_cyc + 1));
            chk("issue_ops", {bus.div_dividend, bus.div_divisor, bus.div_mode},
                {last_op.dvd, last_op.dvs, last_op.mode});
         end
         if (bus.rsp0_valid || bus.rsp1_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
            end else begin
               mon_e = sb.pop_front();
               chk("rsp_id", {bus.rsp1_valid, bus.rsp0_valid}, mon_e.op.id ? 2'b10 : 2'b01);
               chk("rsp_result", bus.rsp_result, mon_e.op.res);
               chk("rsp_status", bus.rsp_status, mon_e.op.st);
               chk("rsp_cycle", 128'(cyc), 128'(mon_e.exp_cyc));
               chk("busy_in_resp", bus.busy, 1'b1);
            end
            rsp_prev = 1'b1;
         end else if (rsp_prev) begin
            chk("busy_after_resp", bus.busy, 1'b0);
            rsp_prev = 1'b0;
         end
      end
   end

   task automatic wait_idle(input string nm, input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         #2;
         done = (q0.size() == 0 && q1.size() == 0 && !drv_valid[0] && !drv_valid[1] &&
                 sb.size() == 0);
      end
      chk({nm, "_idle"}, 128'(done), 128'(1));
   endtask

   initial begin
      int base;
      int iss0;
      int n_iss;

      tbl[0] = mk(0,     80,       3, 0,  26, S_OK);
      tbl[1] = mk(0,     80,       3, 1,   2, S_OK);
      tbl[2] = mk(1,   -100,       7, 1,  -2, S_OK);
      tbl[3] = mk(1,     50,       0, 0,   0, S_DBZ);
      tbl[4] = mk(1,     -5, 'h8000, 1,  -5, S_OK);
      tbl[5] = mk(1,     -7,       2, 0,  -3, S_OK);
      tbl[6] = mk(0,      0, 'hffff, 0,   0, S_OK);
      tbl[7] = mk(0, 123456,    1000, 0, 123, S_OK);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", outs(), '0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Both valid straight after reset: rq0 first, then rq1.
      base = acc_log.size();
      q0.push_back(mk(0, -80, 3, 0, -26, S_OK));
      q1.push_back(mk(1, 100, 7, 0, 14, S_OK));
      wait_idle("pair", 200);
      chk("pair_accepts", 128'(acc_log.size() - base), 128'(2));
      chk("pair_grant0", 128'(acc_log[base]), 128'(0));
      chk("pair_grant1", 128'(acc_log[base + 1]), 128'(1));

      // Single requests, one at a time.
      iss0  = issue_cnt;
      n_iss = 0;
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].id) q1.push_back(tbl[i]);
         else           q0.push_back(tbl[i]);
         if (tbl[i].st != S_DBZ) n_iss++;
         wait_idle("tbl", 200);
         chk("tbl_grant", 128'(acc_log[acc_log.size() - 1]), 128'(tbl[i].id));
      end
      chk("tbl_issue_count", 128'(issue_cnt - iss0), 128'(n_iss));

      // Pointer now at rq1: both held valid should alternate 1,0,1.
      base = acc_log.size();
      q1.push_back(mk(1, 21, 4, 0, 5, S_OK));
      q1.push_back(mk(1, 21, 4, 1, 1, S_OK));
      q0.push_back(mk(0, -9, -2, 0, 4, S_OK));
      wait_idle("alt", 300);
      chk("alt_accepts", 128'(acc_log.size() - base), 128'(3));
      chk("alt_grant0", 128'(acc_log[base]), 128'(1));
      chk("alt_grant1", 128'(acc_log[base + 1]), 128'(0));
      chk("alt_grant2", 128'(acc_log[base + 2]), 128'(1));

      // Stray divider result while idle must be ignored.
      @(posedge clk);
      #1;
      stray = 1'b1;
      @(posedge clk);
      #1;
      stray = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("stray_ignored", {bus.busy, bus.rsp0_valid, bus.rsp1_valid}, 3'b000);

      // Divider never answers: timeout response.
      div_en = 1'b0;
      q0.push_back(mk(0, 9, 3, 0, 0, S_TMO));
      wait_idle("timeout", 200);
      div_en = 1'b1;

      // Reset while waiting on the divider aborts silently and resets the pointer.
      base = acc_log.size();
      q0.push_back(mk(0, 77, 5, 0, 15, S_OK));
      for (int i = 0; i < 50 && acc_log.size() == base; i++) begin
         @(negedge clk);
         #2;
      end
      chk("rst_accept", 128'(acc_log.size() - base), 128'(1));
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("rst_busy_before", bus.busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("rst_outputs", outs(), '0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_outputs_after", outs(), '0);
      base = acc_log.size();
      q1.push_back(mk(1, -77, 5, 1, -2, S_OK));
      q0.push_back(mk(0, 64, -8, 0, -8, S_OK));
      wait_idle("post_rst", 200);
      chk("post_rst_accepts", 128'(acc_log.size() - base), 128'(2));
      chk("post_rst_grant0", 128'(acc_log[base]), 128'(0));
      chk("post_rst_grant1", 128'(acc_log[base + 1]), 128'(1));

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 128'(sb.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running, want done");
      $fatal(1);
   end
endmodule
